seq_divider: RTL and testbench

//   Parametrised multi-cycle radix-2 restoring integer divider with valid/ready handshakes.

---
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 tb/tb_seq_divider.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned per request, with
// valid/ready on both sides, flush, and fixed results for divide-by-zero and MIN/-1.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_V   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_V    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return ~v + ONE_V;
  endfunction

  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? neg_f(v) : v;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r, out_valid_r, busy_r;
  logic             sgn_r, num_neg_r, den_neg_r;
  logic [WIDTH-1:0] q_r, p_r, d_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             dbz_r, ovf_r;

  logic             accept_s, consume_s, dbz_s, ovf_s;
  logic             num_neg_s, den_neg_s, qbit_s;
  logic [WIDTH:0]   shift_s, diff_s;

  assign accept_s  = in_valid & in_ready_r & ~flush;
  assign consume_s = out_valid_r & out_ready;
  assign num_neg_s = is_signed & numerator[WIDTH-1];
  assign den_neg_s = is_signed & denominator[WIDTH-1];
  assign dbz_s     = (denominator == ZERO_V);
  assign ovf_s     = is_signed & (numerator == MIN_V) & (denominator == ONES_V);

  // The (WIDTH+1)-bit partial remainder; a set MSB of the difference means "restore".
  assign shift_s = {p_r, q_r[WIDTH-1]};
  assign diff_s  = shift_s - {1'b0, d_r};
  assign qbit_s  = ~diff_s[WIDTH];

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;
  assign overflow    = ovf_r;

  // Next-state decode; flush overrides every transition.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (dbz_s | ovf_s) state_s = DONE;
            else               state_s = CALC;
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == CNT_LAST) state_s = FIX;
          else                   state_s = CALC;
        end
        FIX:  state_s = DONE;
        DONE: begin
          if (consume_s) state_s = IDLE;
          else           state_s = DONE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, iteration counter and handshake flags; out_valid trails DONE entry by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_r == DONE) && (state_s == DONE);
      if ((state_r == CALC) && (state_s == CALC)) cnt_r <= cnt_r + CNT_ONE;
      else                                        cnt_r <= CNT_ZERO;
    end
  end

  // Operand capture, shift/subtract iteration, sign fix-up and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_r       <= 1'b0;
      num_neg_r   <= 1'b0;
      den_neg_r   <= 1'b0;
      q_r         <= ZERO_V;
      p_r         <= ZERO_V;
      d_r         <= ZERO_V;
      quotient_r  <= ZERO_V;
      remainder_r <= ZERO_V;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (!flush) begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sgn_r     <= is_signed;
            num_neg_r <= num_neg_s;
            den_neg_r <= den_neg_s;
            q_r       <= mag_f(numerator, num_neg_s);
            d_r       <= mag_f(denominator, den_neg_s);
            p_r       <= ZERO_V;
            if (dbz_s) begin
              quotient_r  <= ONES_V;
              remainder_r <= numerator;
              dbz_r       <= 1'b1;
              ovf_r       <= 1'b0;
            end else if (ovf_s) begin
              quotient_r  <= MIN_V;
              remainder_r <= ZERO_V;
              dbz_r       <= 1'b0;
              ovf_r       <= 1'b1;
            end
          end
        end
        CALC: begin
          p_r <= qbit_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
          q_r <= {q_r[WIDTH-2:0], qbit_s};
        end
        FIX: begin
          quotient_r  <= mag_f(q_r, sgn_r & (num_neg_r ^ den_neg_r));
          remainder_r <= mag_f(p_r, sgn_r & num_neg_r);
          dbz_r       <= 1'b0;
          ovf_r       <= 1'b0;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed vector table, multi-cycle
// corner sequences, and randomized requests against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic [31:0] numerator = 32'd0;
  logic [31:0] denominator = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .numerator(numerator), .denominator(denominator),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder takes the dividend's sign, so MIN/-1 falls out as MIN rem 0.
  function automatic void model(input logic s, input logic [31:0] n, input logic [31:0] d,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z, output logic o);
    longint a, b, q64, r64;
    z = 1'b0;
    o = 1'b0;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = n;
      z = 1'b1;
    end else begin
      if (s) begin
        a = longint'($signed(n));
        b = longint'($signed(d));
      end else begin
        a = longint'({32'd0, n});
        b = longint'({32'd0, d});
      end
      q64 = a / b;
      r64 = a % b;
      q = q64[31:0];
      r = r64[31:0];
      o = s && (n == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
    end
  endfunction

  task automatic start_req(input logic s, input logic [31:0] n, input logic [31:0] d);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_req", {63'd0, in_ready}, 64'd1);
    is_signed   = s;
    numerator   = n;
    denominator = d;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [31:0] n, input logic [31:0] d,
                        input int stall, output logic [31:0] q, output logic [31:0] r,
                        output logic z, output logic o, output int lat);
    start_req(s, n, d);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    o = overflow;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_quotient", {32'd0, quotient}, {32'd0, q});
      chk("hold_remainder", {32'd0, remainder}, {32'd0, r});
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_out_valid", {63'd0, out_valid}, 64'd0);
    chk("consume_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic watch_idle(input string name, input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    chk(name, 64'(pulses), 64'd0);
  endtask

  logic [31:0] aq, ar, eq, er, rn, rd;
  logic        az, ao, ez, eo, rs;
  int          alat, mode;

  initial begin
    vt[0]  = '{1'b0, 32'd111,        32'd5,          32'd22,         32'd1,          1'b0, 1'b0, 34};
    vt[1]  = '{1'b1, 32'hFFFF_FF91,  32'd5,          32'hFFFF_FFEA,  32'hFFFF_FFFF,  1'b0, 1'b0, 34};
    vt[2]  = '{1'b1, 32'd111,        32'hFFFF_FFFB,  32'hFFFF_FFEA,  32'd1,          1'b0, 1'b0, 34};
    vt[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 34};
    vt[4]  = '{1'b0, 32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1, 1'b0, 1};
    vt[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 1};
    vt[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0, 34};
    vt[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0, 1};
    vt[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0, 34};
    vt[9]  = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0, 1'b0, 34};
    vt[10] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b0, 34};
    vt[11] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 34};

    // Reset state
    #1 rst_n = 1'b0;
    #10;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_quotient", {32'd0, quotient}, 64'd0);
    chk("reset_remainder", {32'd0, remainder}, 64'd0);
    chk("reset_flags", {62'd0, div_by_zero, overflow}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].s, vt[i].n, vt[i].d, 0, aq, ar, az, ao, alat);
      chk($sformatf("vec%0d_quotient", i), {32'd0, aq}, {32'd0, vt[i].q});
      chk($sformatf("vec%0d_remainder", i), {32'd0, ar}, {32'd0, vt[i].r});
      chk($sformatf("vec%0d_div_by_zero", i), {63'd0, az}, {63'd0, vt[i].z});
      chk($sformatf("vec%0d_overflow", i), {63'd0, ao}, {63'd0, vt[i].o});
      chk($sformatf("vec%0d_latency", i), 64'(alat), 64'(vt[i].lat));
    end

    // Backpressure: ten stalled cycles, then a back-to-back request
    run_op(1'b0, 32'd1000, 32'd3, 10, aq, ar, az, ao, alat);
    chk("bp_quotient", {32'd0, aq}, 64'd333);
    chk("bp_remainder", {32'd0, ar}, 64'd1);
    run_op(1'b0, 32'd100, 32'd7, 0, aq, ar, az, ao, alat);
    chk("bp_next_quotient", {32'd0, aq}, 64'd14);
    chk("bp_next_latency", 64'(alat), 64'd34);

    // flush at CALC cycle 5
    start_req(1'b0, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    watch_idle("flush_no_result", 40);
    run_op(1'b0, 32'd100, 32'd7, 0, aq, ar, az, ao, alat);
    chk("after_flush_quotient", {32'd0, aq}, 64'd14);
    chk("after_flush_remainder", {32'd0, ar}, 64'd2);

    // Reset mid-CALC
    start_req(1'b1, 32'hFFFF_FC18, 32'd9);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_quotient", {32'd0, quotient}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_idle("midrst_no_result", 40);
    run_op(1'b0, 32'd100, 32'd7, 0, aq, ar, az, ao, alat);
    chk("after_rst_quotient", {32'd0, aq}, 64'd14);
    chk("after_rst_remainder", {32'd0, ar}, 64'd2);

    // flush together with an accepting request in IDLE drops it
    @(negedge clk);
    numerator   = 32'd5;
    denominator = 32'd1;
    in_valid    = 1'b1;
    flush       = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_accept_busy", {63'd0, busy}, 64'd0);
    watch_idle("flush_accept_no_result", 40);

    // Randomized requests against the reference model
    for (int k = 0; k < 40; k++) begin
      rs   = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 5));
      rn   = $urandom;
      rd   = $urandom;
      if (mode == 0) begin
        rd = 32'd0;
      end else if (mode == 1) begin
        rd = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) rd = -rd;
      end else if (mode == 2) begin
        rn = 32'h8000_0000;
        rd = 32'hFFFF_FFFF;
      end else if (mode == 3) begin
        rn = 32'($urandom_range(0, 1000));
      end
      model(rs, rn, rd, eq, er, ez, eo);
      run_op(rs, rn, rd, int'($urandom_range(0, 2)), aq, ar, az, ao, alat);
      chk($sformatf("rnd%0d_quotient s=%0d %0h/%0h", k, rs, rn, rd), {32'd0, aq}, {32'd0, eq});
      chk($sformatf("rnd%0d_remainder s=%0d %0h/%0h", k, rs, rn, rd), {32'd0, ar}, {32'd0, er});
      chk($sformatf("rnd%0d_flags", k), {62'd0, az, ao}, {62'd0, ez, eo});
      chk($sformatf("rnd%0d_latency", k), 64'(alat), (ez || eo) ? 64'd1 : 64'd34);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
